// File: rtl/pac_anim_seq.sv
// Sprite animation sequencer: writable bitmap table, per-direction loop or ping-pong frame
// stepping on a prescaled tick, and a one-shot death sequence ending in a held last frame.
module pac_anim_seq #(
    parameter int unsigned SIDE         = 5,
    parameter int unsigned FRAMES       = 2,
    parameter int unsigned DEATH_FRAMES = 4,
    parameter int unsigned PRESCALE     = 1,
    parameter int unsigned PINGPONG     = 0,
    localparam int unsigned W     = SIDE * SIDE,
    localparam int unsigned DEPTH = 4 * FRAMES + DEATH_FRAMES,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned FMAX  = (FRAMES > DEATH_FRAMES) ? FRAMES : DEATH_FRAMES,
    localparam int unsigned FW    = (FMAX > 1) ? $clog2(FMAX) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          tick,
    input  logic [2:0]    dir_in,
    input  logic          freeze,
    input  logic          die,
    input  logic          revive,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    output logic [W-1:0]  shape,
    output logic [1:0]    cur_dir,
    output logic [FW-1:0] frame,
    output logic          dying,
    output logic          done
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {StRun, StDying, StDead} state_e;

    state_e        state_q, state_d;
    logic [1:0]    dir_q, dir_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          up_q, up_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  table_q [DEPTH];
    logic [AW-1:0] idx;

    logic          cnt_wrap, step;
    logic [CW-1:0] cnt_next;

    assign cnt_wrap = (cnt_q == CW'(PRESCALE - 1));
    assign step     = tick && cnt_wrap;
    assign cnt_next = cnt_wrap ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
            dir_q   <= 2'd0;
            frame_q <= '0;
            up_q    <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            frame_q <= frame_d;
            up_q    <= up_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        frame_d = frame_q;
        up_d    = up_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRun: begin
                if (die) begin
                    state_d = StDying;
                    frame_d = '0;
                    cnt_d   = '0;
                end else if (tick && !freeze) begin
                    cnt_d = cnt_next;
                    if (step) begin
                        if (!dir_in[2]) dir_d = dir_in[1:0];
                        if (FRAMES == 1) begin
                            frame_d = '0;
                        end else if (PINGPONG == 0) begin
                            frame_d = (frame_q == FW'(FRAMES - 1)) ? '0 : frame_q + 1'b1;
                        end else if (up_q) begin
                            // Turn around at the top without repeating the endpoint.
                            if (frame_q == FW'(FRAMES - 1)) begin
                                up_d    = 1'b0;
                                frame_d = frame_q - 1'b1;
                            end else begin
                                frame_d = frame_q + 1'b1;
                            end
                        end else begin
                            if (frame_q == '0) begin
                                up_d    = 1'b1;
                                frame_d = frame_q + 1'b1;
                            end else begin
                                frame_d = frame_q - 1'b1;
                            end
                        end
                    end
                end
            end
            StDying: begin
                if (tick) begin
                    cnt_d = cnt_next;
                    if (step) begin
                        if (frame_q == FW'(DEATH_FRAMES - 1)) state_d = StDead;
                        else frame_d = frame_q + 1'b1;
                    end
                end
            end
            StDead: begin
                if (revive) begin
                    state_d = StRun;
                    dir_d   = 2'd0;
                    frame_d = '0;
                    up_d    = 1'b1;
                    cnt_d   = '0;
                end else if (tick) begin
                    cnt_d = cnt_next;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) table_q[i] <= '0;
        end else if (wr_en && (32'(wr_addr) < DEPTH)) begin
            table_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        if (state_q == StRun) idx = AW'(dir_q) * AW'(FRAMES) + AW'(frame_q);
        else idx = AW'(4 * FRAMES) + AW'(frame_q);
    end

    assign shape   = table_q[idx];
    assign cur_dir = dir_q;
    assign frame   = frame_q;
    assign dying   = (state_q == StDying);
    assign done    = (state_q == StDead);

endmodule

// File: tb/tb_pac_anim_seq.sv
// Scoreboard bench for pac_anim_seq: a loop-order and a ping-pong instance share stimulus and
// are compared every cycle against a sequence-position reference model.
module tb_pac_anim_seq;

    localparam int F0 = 4, D0 = 4, P0 = 3, PP0 = 0;
    localparam int F1 = 3, D1 = 3, P1 = 1, PP1 = 1;

    typedef struct packed {
        logic [24:0] shape;
        logic [1:0]  dir;
        logic [1:0]  frame;
        logic        dying;
        logic        done;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0, freeze = 1'b0, die = 1'b0, revive = 1'b0, wr_en = 1'b0;
    logic [2:0]  dir_in = 3'd0;
    logic [4:0]  wr_addr = 5'd0;
    logic [24:0] wr_data = 25'd0;

    logic [24:0] shape0, shape1;
    logic [1:0]  cur_dir0, cur_dir1, frame0, frame1;
    logic        dying0, dying1, done0, done1;

    pac_anim_seq #(.SIDE(5), .FRAMES(F0), .DEATH_FRAMES(D0), .PRESCALE(P0), .PINGPONG(PP0))
    u_loop (
        .clock(clock), .reset(reset), .tick(tick), .dir_in(dir_in), .freeze(freeze),
        .die(die), .revive(revive), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .shape(shape0), .cur_dir(cur_dir0), .frame(frame0), .dying(dying0), .done(done0)
    );

    pac_anim_seq #(.SIDE(5), .FRAMES(F1), .DEATH_FRAMES(D1), .PRESCALE(P1), .PINGPONG(PP1))
    u_pp (
        .clock(clock), .reset(reset), .tick(tick), .dir_in(dir_in), .freeze(freeze),
        .die(die), .revive(revive), .wr_en(wr_en), .wr_addr(wr_addr[3:0]), .wr_data(wr_data),
        .shape(shape1), .cur_dir(cur_dir1), .frame(frame1), .dying(dying1), .done(done1)
    );

    always #5 clock = ~clock;

    // Reference model: run state tracks a position within the frame cycle, not a phase bit.
    int mF[2]  = '{F0, F1};
    int mD[2]  = '{D0, D1};
    int mP[2]  = '{P0, P1};
    int mPP[2] = '{PP0, PP1};
    int st[2], cdir[2], pos[2], dpos[2], cnt[2];
    logic [24:0] mtbl [2][32];

    exp_t q0[$], q1[$];
    int total = 0, bad = 0;
    bit mon_en = 1'b0;
    event sample;

    function automatic int period(int i);
        if (mF[i] == 1) return 1;
        return (mPP[i] != 0) ? 2 * mF[i] - 2 : mF[i];
    endfunction

    function automatic int run_frame(int i);
        if (mPP[i] != 0 && pos[i] >= mF[i]) return period(i) - pos[i];
        return pos[i];
    endfunction

    function automatic exp_t expect_of(int i);
        exp_t e;
        int fr, idx;
        fr  = (st[i] == 0) ? run_frame(i) : dpos[i];
        idx = (st[i] == 0) ? cdir[i] * mF[i] + fr : 4 * mF[i] + dpos[i];
        e.shape = mtbl[i][idx];
        e.dir   = 2'(cdir[i]);
        e.frame = 2'(fr);
        e.dying = (st[i] == 1);
        e.done  = (st[i] == 2);
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            st[i] = 0; cdir[i] = 0; pos[i] = 0; dpos[i] = 0; cnt[i] = 0;
            for (int a = 0; a < 32; a++) mtbl[i][a] = 25'd0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int a;
            bit stp;
            a = int'(wr_addr) & ((i == 0) ? 31 : 15);
            if (wr_en && a < 4 * mF[i] + mD[i]) mtbl[i][a] = wr_data;
            stp = (cnt[i] == mP[i] - 1);
            case (st[i])
                0: begin
                    if (die) begin
                        st[i] = 1; dpos[i] = 0; cnt[i] = 0;
                    end else if (tick && !freeze) begin
                        cnt[i] = stp ? 0 : cnt[i] + 1;
                        if (stp) begin
                            if (dir_in < 3'd4) cdir[i] = int'(dir_in);
                            pos[i] = (pos[i] + 1) % period(i);
                        end
                    end
                end
                1: begin
                    if (tick) begin
                        cnt[i] = stp ? 0 : cnt[i] + 1;
                        if (stp) begin
                            if (dpos[i] == mD[i] - 1) st[i] = 2;
                            else dpos[i] = dpos[i] + 1;
                        end
                    end
                end
                default: begin
                    if (revive) begin
                        st[i] = 0; cdir[i] = 0; pos[i] = 0; cnt[i] = 0;
                    end else if (tick) begin
                        cnt[i] = stp ? 0 : cnt[i] + 1;
                    end
                end
            endcase
        end
    endtask

    task automatic push_exp();
        q0.push_back(expect_of(0));
        q1.push_back(expect_of(1));
    endtask

    // Drive inputs for the coming edge and queue what the outputs must be after it.
    task automatic apply(input bit t, input logic [2:0] d, input bit fz, input bit di,
                         input bit rv, input bit we, input logic [4:0] a,
                         input logic [24:0] data);
        tick = t; dir_in = d; freeze = fz; die = di; revive = rv;
        wr_en = we; wr_addr = a; wr_data = data;
        model_edge();
        push_exp();
    endtask

    task automatic cycle(input bit t, input logic [2:0] d, input bit fz, input bit di,
                         input bit rv, input bit we, input logic [4:0] a,
                         input logic [24:0] data);
        @(negedge clock);
        apply(t, d, fz, di, rv, we, a, data);
    endtask

    // Pulse reset between edges and check the outputs before the next edge.
    task automatic async_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        model_reset();
        push_exp();
        ->sample;
        #1;
        reset = 1'b0;
        apply(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 25'd0);
    endtask

    always begin
        @(posedge clock);
        #1;
        if (mon_en) ->sample;
    end

    task automatic check(input int i, input exp_t act, input exp_t want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL inst%0d t=%0t: got shape=%h dir=%0d frame=%0d dying=%b done=%b, want shape=%h dir=%0d frame=%0d dying=%b done=%b",
                     i, $time, act.shape, act.dir, act.frame, act.dying, act.done,
                     want.shape, want.dir, want.frame, want.dying, want.done);
        end
    endtask

    initial begin
        forever begin
            @(sample);
            if (q0.size() == 0 || q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard underflow t=%0t: got q0=%0d q1=%0d entries, want >=1",
                         $time, q0.size(), q1.size());
            end else begin
                check(0, {shape0, cur_dir0, frame0, dying0, done0}, q0.pop_front());
                check(1, {shape1, cur_dir1, frame1, dying1, done1}, q1.pop_front());
            end
        end
    end

    initial begin
        repeat (2) @(negedge clock);
        model_reset();
        push_exp();
        mon_en = 1'b1;
        ->sample;
        #1;
        reset = 1'b0;
        apply(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 25'h1ABCDEF);
        for (int a = 1; a < 32; a++)
            cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'(a), 25'($urandom));
        repeat (12) cycle(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 25'd0);
        cycle(1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 25'd0);
        repeat (3) cycle(1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 25'd0);
        repeat (3) cycle(1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 25'd0);
        repeat (5) cycle(1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 25'd0);
        cycle(1'b0, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 25'd0);
        repeat (14) cycle(1'b1, 3'd1, 1'b1, 1'b1, 1'b1 & 1'b0, 1'b0, 5'd0, 25'd0);
        cycle(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 25'd0);
        cycle(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 25'd0);
        cycle(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 25'd0);
        async_reset();
        repeat (3000) begin
            if ($urandom_range(249) == 0) begin
                async_reset();
            end else begin
                cycle(1'($urandom_range(1)), 3'($urandom_range(7)), $urandom_range(6) == 0,
                      $urandom_range(40) == 0, $urandom_range(4) == 0,
                      $urandom_range(2) == 0, 5'($urandom_range(31)), 25'($urandom));
            end
        end
        @(posedge clock);
        #3;
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL scoreboard drain: got q0=%0d q1=%0d left, want 0", q0.size(),
                     q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pac_anim_seq.md
# pac_anim_seq

Parametrised sprite animation sequencer, the successor to the fixed two-frame Pac-Man shaper. It holds a writable bitmap table of FRAMES frames per direction plus a DEATH_FRAMES one-shot death sequence. It steps frames on a prescaled tick, in either loop or ping-pong order, and drives the current SIDE×SIDE bitmap to the sprite renderer. It sits between the movement controller (`dir_in`, `die`, `revive`) and the VGA sprite drawer (`shape`).

## Interface
- SIDE, 5, sprite edge in pixels; `shape` width is W = SIDE*SIDE.
- FRAMES, 2, frames per movement direction (≥1).
- DEATH_FRAMES, 4, frames in the death sequence (≥1).
- PRESCALE, 1, `tick` strobes per frame step (≥1).
- PINGPONG, 0, 0 = loop order 0..F-1,0,…; 1 = ping-pong order 0..F-1..0.
- DEPTH (derived), 4*FRAMES+DEATH_FRAMES, table entries; AW = clog2(DEPTH).
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle animation strobe.
- dir_in  in  3  000 RIGHT, 001 UP, 010 LEFT, 011 DOWN, 100 WAIT; 101–111 are treated as WAIT.
- freeze  in  1  suppresses frame stepping in RUN.
- die  in  1  starts the death sequence.
- revive  in  1  leaves DEAD.
- wr_en  in  1  table write strobe.
- wr_addr  in  AW  table entry; direction d, frame f is at d*FRAMES+f; death frame k is at 4*FRAMES+k.
- wr_data  in  W  bitmap to write.
- shape  out  W  current bitmap, table[idx].
- cur_dir  out  2  latched direction.
- frame  out  clog2(max(FRAMES,DEATH_FRAMES))  current frame index.
- dying  out  1  high while in DYING.
- done  out  1  high while in DEAD.

## Operation
- **Reset values:**
  - state = RUN, `cur_dir` = RIGHT, `frame` = 0.
  - Ping-pong phase = up, prescaler `cnt` = 0.
  - All table entries = 0, so `shape` = 0.
  - `dying` = 0, `done` = 0.
- **Step:** `step = tick && cnt == PRESCALE-1`.
  - On any `tick`, `cnt` increments and wraps to 0 at PRESCALE-1.
  - In RUN with `freeze` = 1, `cnt` holds and no step occurs.
- **RUN:**
  - On step with a valid direction: `cur_dir` ← `dir_in` and `frame` advances.
  - Phase is preserved across a direction change: RIGHT frame 1 followed by UP gives UP frame 2 mod F in loop order.
  - WAIT keeps `cur_dir` and still advances `frame`.
  - `idx` = `cur_dir`*FRAMES + `frame`.
- **Advance rules:**
  - Loop order: `frame` = (`frame`+1) mod FRAMES.
  - Ping-pong order: `frame` counts up to FRAMES-1, then the phase flips and it counts down to 0, then flips again. No endpoint is repeated.
  - FRAMES = 1: `frame` stays 0.
  - FRAMES = 2: ping-pong order is identical to loop order.
- **RUN → DYING:** taken when `die` = 1 at an edge, independent of `tick`.
  - `frame` ← 0, `cnt` ← 0.
  - `idx` = 4*FRAMES + `frame`.
- **DYING:**
  - `freeze`, `dir_in` and `die` are ignored.
  - On each step, `frame` increments.
  - A step at `frame` = DEATH_FRAMES-1 goes to DEAD with `frame` held at DEATH_FRAMES-1, so the last death bitmap stays displayed.
- **DEAD:**
  - `done` = 1.
  - `revive` = 1 → RUN with `cur_dir` = RIGHT, `frame` = 0, phase = up, `cnt` = 0.
- **Ignored or conflicting inputs:**
  - `revive` is ignored in RUN and DYING.
  - `die` and `revive` both high in RUN: `die` wins.
  - `die` is ignored in DEAD.
- **Table writes:**
  - `wr_en` writes `wr_data` to table[`wr_addr`] in any state.
  - `wr_addr` ≥ DEPTH is ignored.
  - A write never alters the sequencer state.

## Timing
- All state is updated on the rising edge of `clock`. `reset` clears asynchronously, at any time, including mid-death.
- `shape` is a combinational read of the registered table at the registered `idx`.
  - A step sampled at edge t shows the new bitmap after edge t.
  - A write at edge t to the displayed entry shows after edge t.
  - A write and a step at the same edge: the new `idx` reads the post-write table.
- `dying` and `done` are registered state decodes, valid the cycle after the transition edge.
- There is no handshake. `tick` may be high on consecutive cycles; each high cycle counts.

## Test plan
- **Reset and write:** reset; write table[0] = 25'h1ABCDEF → `shape` = 25'h1ABCDEF, `cur_dir` = 0, `frame` = 0, `done` = 0.
- **Loop with prescaler:** FRAMES=4, PRESCALE=3, `dir_in` = UP, 12 ticks → `frame` sequence 1,2,3,0 at every 3rd tick, `cur_dir` = 1.
- **Ping-pong:** PINGPONG=1, FRAMES=4, 8 steps → `frame` 1,2,3,2,1,0,1,2.
- **Direction change, WAIT and freeze:** RIGHT frame 1, step with LEFT → `cur_dir` = 2, `frame` = 0 (FRAMES=2). Step with WAIT (100) and with 110 → `cur_dir` stays 2, `frame` toggles each step. `freeze` = 1 with 5 ticks → `frame` unchanged.
- **Death sequence:** DEATH_FRAMES=4, PRESCALE=1, pulse `die` together with `revive` → `dying` = 1, `frame` = 0; 4 ticks → `frame` 1,2,3, then DEAD with `done` = 1 and `shape` = table[4*FRAMES+3]. `revive` → RUN, `cur_dir` = 0, `frame` = 0.
- **Async reset mid-death:** assert `reset` between edges during DYING → outputs immediately return to reset values, the table is cleared, and `shape` = 0.
